// File: rtl/shift_pkg.sv
// Shared types for the shift arbiter: operand width, request record and buffer state.
package shift_pkg;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] num;
    logic [AMT_W-1:0] amt;
    logic             lr;
  } shift_req_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } shift_arb_state_e;

endpackage

// File: rtl/shift_arbiter_if.sv
// Two-requester valid/ready request bus plus the registered result channel.
interface shift_arbiter_if;
  import shift_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_num;
  logic [AMT_W-1:0] req0_amt;
  logic             req0_lr;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_num;
  logic [AMT_W-1:0] req1_amt;
  logic             req1_lr;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_id;

  // master: the client side (requesters and result consumer)
  modport master (
    output req0_valid, req0_num, req0_amt, req0_lr,
    output req1_valid, req1_num, req1_amt, req1_lr,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req0_valid, req0_num, req0_amt, req0_lr,
    input  req1_valid, req1_num, req1_amt, req1_lr,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_data, resp_id
  );

endinterface

// File: rtl/sixteenBitBarrelShifter.sv
// 16-bit rotator: lr=1 rotates right by amt, lr=0 rotates left by amt.
module sixteenBitBarrelShifter
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] num,
  input  logic [AMT_W-1:0] amt,
  input  logic             lr,
  output logic [WIDTH-1:0] shiftedNum
);

  logic [AMT_W-1:0]   eff_amt;
  logic [2*WIDTH-1:0] doubled;

  // A left rotate by amt equals a right rotate by (-amt) mod 16
  assign eff_amt    = lr ? amt : -amt;
  assign doubled    = {num, num};
  assign shiftedNum = WIDTH'(doubled >> eff_amt);

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two requesters,
// with a one-entry result buffer that supports pop-and-accept in one cycle.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input logic      clk,
  input logic      rst,
  shift_arbiter_if.slave bus
);

  if (N_REQ != 2) begin : g_nreq_check
    $error("shift_arbiter supports exactly two requesters");
  end

  shift_arb_state_e state_q, state_d;
  logic             last_grant_q;
  logic [WIDTH-1:0] resp_data_q;
  logic             resp_id_q;
  logic             can_accept;
  logic             grant0, grant1;
  logic             accept;
  shift_req_t       req0, req1, sel_req;
  logic [WIDTH-1:0] shifted;

  assign req0 = '{num: bus.req0_num, amt: bus.req0_amt, lr: bus.req0_lr};
  assign req1 = '{num: bus.req1_num, amt: bus.req1_amt, lr: bus.req1_lr};

  assign can_accept = (state_q == EMPTY) | bus.resp_ready;

  // On a tie the requester not named by last_grant wins
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);

  assign bus.req0_ready = can_accept & grant0;
  assign bus.req1_ready = can_accept & grant1;
  assign accept         = bus.req0_ready | bus.req1_ready;

  assign sel_req = grant1 ? req1 : req0;

  sixteenBitBarrelShifter u_shifter (
    .num        (sel_req.num),
    .amt        (sel_req.amt),
    .lr         (sel_req.lr),
    .shiftedNum (shifted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept)
      state_d = FULL;
    else if ((state_q == FULL) && bus.resp_ready)
      state_d = EMPTY;
  end

  // Data, id and grant history move only on accept; a plain pop leaves them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      resp_data_q  <= shifted;
      resp_id_q    <= grant1;
      last_grant_q <= grant1;
    end
  end

  assign bus.resp_valid = (state_q == FULL);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;

  a_one_ready: assert property (@(posedge clk) disable iff (rst)
    !(bus.req0_ready && bus.req1_ready));

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed table-driven bench for shift_arbiter plus hand-written async-reset sequence.
module tb_shift_arbiter;
  import shift_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  shift_arbiter_if bus ();

  shift_arbiter #(.N_REQ(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [15:0] n0;
    logic [3:0]  a0;
    logic        l0;
    logic        v1;
    logic [15:0] n1;
    logic [3:0]  a1;
    logic        l1;
    logic        rr;
    logic        er0;
    logic        er1;
    logic        erv;
    logic [15:0] ed;
    logic        eid;
  } vec_t;

  vec_t tab[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [15:0] n0, input logic [3:0] a0, input logic l0,
                       input logic v1, input logic [15:0] n1, input logic [3:0] a1, input logic l1,
                       input logic rr);
    bus.req0_valid = v0; bus.req0_num = n0; bus.req0_amt = a0; bus.req0_lr = l0;
    bus.req1_valid = v1; bus.req1_num = n1; bus.req1_amt = a1; bus.req1_lr = l1;
    bus.resp_ready = rr;
  endtask

  task automatic check_resp(input string tag, input logic erv, input logic [15:0] ed, input logic eid);
    check({tag, ".resp_valid"}, 16'(bus.resp_valid), 16'(erv));
    check({tag, ".resp_data"},  bus.resp_data, ed);
    check({tag, ".resp_id"},    16'(bus.resp_id), 16'(eid));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(0, 16'h0, 4'h0, 0, 0, 16'h0, 4'h0, 0, 0);

    //           v0  n0       a0  l0  v1  n1       a1  l1  rr  r0  r1  rv  data     id
    tab.push_back('{1, 16'h8001, 1,  1,  0, 16'h0000, 0,  0,  1,  1,  0,  1, 16'hC000, 0}); // single req0
    tab.push_back('{0, 16'h0000, 0,  0,  1, 16'h1234, 4,  0,  1,  0,  1,  1, 16'h2341, 1}); // left rotate
    tab.push_back('{0, 16'h0000, 0,  0,  1, 16'h1234, 0,  0,  1,  0,  1,  1, 16'h1234, 1}); // amt 0
    tab.push_back('{1, 16'h0001, 15, 0,  1, 16'hFFFE, 8,  1,  1,  1,  0,  1, 16'h8000, 0}); // tie x4
    tab.push_back('{1, 16'h0001, 15, 0,  1, 16'hFFFE, 8,  1,  1,  0,  1,  1, 16'hFEFF, 1});
    tab.push_back('{1, 16'h0001, 15, 0,  1, 16'hFFFE, 8,  1,  1,  1,  0,  1, 16'h8000, 0});
    tab.push_back('{1, 16'h0001, 15, 0,  1, 16'hFFFE, 8,  1,  1,  0,  1,  1, 16'hFEFF, 1});
    tab.push_back('{1, 16'h0001, 15, 0,  1, 16'hFFFE, 8,  1,  0,  0,  0,  1, 16'hFEFF, 1}); // backpressure x3
    tab.push_back('{1, 16'h0001, 15, 0,  1, 16'hFFFE, 8,  1,  0,  0,  0,  1, 16'hFEFF, 1});
    tab.push_back('{1, 16'h0001, 15, 0,  1, 16'hFFFE, 8,  1,  0,  0,  0,  1, 16'hFEFF, 1});
    tab.push_back('{1, 16'h8001, 1,  1,  0, 16'h0000, 0,  0,  1,  1,  0,  1, 16'hC000, 0}); // pop + accept
    tab.push_back('{0, 16'h0000, 0,  0,  0, 16'h0000, 0,  0,  1,  0,  0,  0, 16'hC000, 0}); // drain
    tab.push_back('{0, 16'h0000, 0,  0,  0, 16'h0000, 0,  0,  0,  0,  0,  0, 16'hC000, 0}); // idle
    tab.push_back('{1, 16'h0001, 15, 0,  1, 16'hFFFE, 8,  1,  0,  0,  1,  1, 16'hFEFF, 1}); // tie -> req1
    tab.push_back('{1, 16'h0001, 15, 0,  1, 16'hFFFE, 8,  1,  0,  0,  0,  1, 16'hFEFF, 1}); // stalled tie
    tab.push_back('{1, 16'h0001, 15, 0,  1, 16'hFFFE, 8,  1,  1,  1,  0,  1, 16'h8000, 0}); // tie -> req0

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_resp("reset", 1'b0, 16'h0000, 1'b0);
    check("reset.req0_ready", 16'(bus.req0_ready), 16'h0);
    check("reset.req1_ready", 16'(bus.req1_ready), 16'h0);

    for (int i = 0; i < tab.size(); i++) begin
      @(negedge clk);
      drive(tab[i].v0, tab[i].n0, tab[i].a0, tab[i].l0,
            tab[i].v1, tab[i].n1, tab[i].a1, tab[i].l1, tab[i].rr);
      #1;
      check($sformatf("vec%0d.req0_ready", i), 16'(bus.req0_ready), 16'(tab[i].er0));
      check($sformatf("vec%0d.req1_ready", i), 16'(bus.req1_ready), 16'(tab[i].er1));
      @(posedge clk);
      #1;
      check_resp($sformatf("vec%0d", i), tab[i].erv, tab[i].ed, tab[i].eid);
    end

    // Buffer is FULL and last winner was req0; an async reset must clear both.
    @(negedge clk);
    drive(0, 16'h0, 4'h0, 0, 0, 16'h0, 4'h0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_resp("async_rst", 1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(1, 16'h0001, 4'd15, 0, 1, 16'hFFFE, 4'd8, 1, 1);
    #1;
    check("post_rst.req0_ready", 16'(bus.req0_ready), 16'h1);
    check("post_rst.req1_ready", 16'(bus.req1_ready), 16'h0);
    @(posedge clk);
    #1;
    check_resp("post_rst", 1'b1, 16'h8000, 1'b0);

    @(negedge clk);
    drive(0, 16'h0, 4'h0, 0, 0, 16'h0, 4'h0, 0, 1);
    @(posedge clk);
    #1;
    check("final_drain.resp_valid", 16'(bus.resp_valid), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
